ysyx_23060025_lsu_axi: RTL

Parametrised load/store unit sitting between EXU and WBU, driving the data-side AXI4-Lite master port. Successor to the single-width LSU: DATA_LEN is 32 or 64, upstream and downstream use valid/ready handshakes, AW and W handshake independently, bus responses are checked for errors, and write data and strobes are always lane-shifted to the byte offset. Word-crossing misaligned accesses can optionally be split into two bus beats.

---
 rtl/ysyx_23060025_lsu_axi.sv | 329 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ysyx_23060025_lsu_axi.sv
// ysyx_23060025_lsu_axi -- load/store unit between EXU and WBU, master of the
// data-side AXI4-Lite port.
//
// Parameters: DATA_LEN (32 or 64), ADDR_LEN.
// Ports:
//   clock, reset          sole clock, synchronous active-high reset
//   in_*                  request from EXU (address/ALU result, store data,
//                         load/store type, destination register)
//   out_*                 result to WBU (write data, register, fault info)
//   ar*/r*                AXI read address / read data channels
//   aw*/w*/b*             AXI write address / write data / write response
//   dbg_state             current FSM state (IDLE=0, ADDR=1, RESP=2, DONE=3)
//
// Optional feature: define LSU_MISALIGN_SPLIT_EN to split word-crossing
// accesses into two bus beats. Without it a crossing access faults without
// touching the bus.
//
// Handshake rule (every channel, upstream and downstream): a transfer happens
// on a rising clock edge where valid and ready are both high. A valid, once
// raised, stays high with stable payload until that transfer; all valids and
// readies driven here are registers decoded from state, never combinational
// functions of the partner's valid/ready.
module ysyx_23060025_lsu_axi #(
  parameter int DATA_LEN = 32,
  parameter int ADDR_LEN = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [ADDR_LEN-1:0]   in_addr,
  input  logic [DATA_LEN-1:0]   in_wdata,
  input  logic [2:0]            in_load_type,
  input  logic [2:0]            in_store_type,
  input  logic [4:0]            in_wreg,
  input  logic                  in_wd,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_LEN-1:0]   out_wdata,
  output logic [4:0]            out_wreg,
  output logic                  out_wd,
  output logic                  out_fault,
  output logic [ADDR_LEN-1:0]   out_fault_addr,
  output logic [ADDR_LEN-1:0]   araddr,
  output logic [2:0]            arsize,
  output logic                  arvalid,
  input  logic                  arready,
  input  logic [DATA_LEN-1:0]   rdata,
  input  logic [1:0]            rresp,
  input  logic                  rvalid,
  output logic                  rready,
  output logic [ADDR_LEN-1:0]   awaddr,
  output logic [2:0]            awsize,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [DATA_LEN-1:0]   wdata,
  output logic [DATA_LEN/8-1:0] wstrb,
  output logic                  wvalid,
  input  logic                  wready,
  input  logic [1:0]            bresp,
  input  logic                  bvalid,
  output logic                  bready,
  output logic [1:0]            dbg_state
);

  localparam int B     = DATA_LEN / 8;
  localparam int B2    = 2 * B;
  localparam int OFF_W = $clog2(B);

`ifdef LSU_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, RESP = 2'd2, DONE = 2'd3} state_t;
  state_t state_q;

  // Latched request
  logic [ADDR_LEN-1:0] addr_q;
  logic [DATA_LEN-1:0] wdata_q;
  logic [2:0]          ld_type_q;
  logic [1:0]          lg_q;       // log2 of access bytes
  logic                is_load_q;
  logic                cross_q;
  logic                beat_q;     // 0 = first beat, 1 = second beat of a split
  logic [DATA_LEN-1:0] rbuf_q;     // beat-0 read data of a split load
  logic [OFF_W-1:0]    off_q;

  assign off_q     = addr_q[OFF_W-1:0];
  assign in_ready  = (state_q == IDLE);
  assign dbg_state = state_q;

  function automatic logic [1:0] load_lg(input logic [2:0] lt);
    case (lt)
      3'd2, 3'd5: return 2'd1;
      3'd3, 3'd6: return 2'd2;
      3'd7:       return 2'd3;
      default:    return 2'd0;
    endcase
  endfunction

  // Left-justify the n valid bytes, then shift back arithmetically or
  // logically; this stays legal for both bus widths.
  function automatic logic [DATA_LEN-1:0] extend_load(input logic [DATA_LEN-1:0] v,
                                                      input logic [2:0] lt,
                                                      input logic [1:0] lg);
    logic [DATA_LEN-1:0] t;
    int sh;
    sh = DATA_LEN - (8 << lg);
    if (sh < 0) sh = 0;
    t = v << sh;
    if (lt == 3'd1 || lt == 3'd2 || lt == 3'd3) return DATA_LEN'($signed(t) >>> sh);
    return t >> sh;
  endfunction

  // Request decode; 64-bit types on a 32-bit bus degrade to "none".
  logic [2:0] in_lt_n, in_st_n;
  logic       in_is_load, in_is_store, in_cross;
  logic [1:0] in_lg;

  always_comb begin
    in_lt_n = in_load_type;
    if (DATA_LEN == 32 && in_load_type >= 3'd6) in_lt_n = 3'd0;
    in_st_n = in_store_type;
    if (in_store_type > 3'd4 || (DATA_LEN == 32 && in_store_type == 3'd4)) in_st_n = 3'd0;
    in_is_load  = (in_lt_n != 3'd0);
    in_is_store = !in_is_load && (in_st_n != 3'd0);
    in_lg       = in_is_load ? load_lg(in_lt_n) : 2'(in_st_n - 3'd1);
    in_cross    = (in_is_load || in_is_store) &&
                  ((32'(in_addr[OFF_W-1:0]) + (32'd1 << in_lg)) > 32'(B));
  end

  // Beat issue values. In IDLE they describe beat 0 of the incoming request;
  // elsewhere they describe beat 1 of the latched request.
  logic [ADDR_LEN-1:0]   src_addr, base_addr, iss_addr;
  logic [DATA_LEN-1:0]   src_wdata, iss_wdata;
  logic [1:0]            src_lg;
  logic                  src_cross, src_beat;
  logic [OFF_W-1:0]      src_off;
  logic [2:0]            iss_size;
  logic [B2-1:0]         strb_mask, wide_strb;
  logic [2*DATA_LEN-1:0] wide_wdata;
  logic [B-1:0]          iss_wstrb;

  always_comb begin
    if (state_q == IDLE) begin
      src_addr  = in_addr;
      src_wdata = in_wdata;
      src_lg    = in_lg;
      src_cross = in_cross;
      src_beat  = 1'b0;
    end else begin
      src_addr  = addr_q;
      src_wdata = wdata_q;
      src_lg    = lg_q;
      src_cross = cross_q;
      src_beat  = 1'b1;
    end
    src_off   = src_addr[OFF_W-1:0];
    base_addr = src_addr & ~ADDR_LEN'(B - 1);
    iss_addr  = src_cross ? (src_beat ? base_addr + ADDR_LEN'(B) : base_addr) : src_addr;
    iss_size  = src_cross ? 3'(OFF_W) : {1'b0, src_lg};
    case (src_lg)
      2'd0:    strb_mask = B2'(1);
      2'd1:    strb_mask = B2'(3);
      2'd2:    strb_mask = B2'(4'hF);
      default: strb_mask = B2'(8'hFF);
    endcase
    // Double-width shift: the low half is beat 0, whatever spills into the
    // high half belongs to beat 1 of a crossing store.
    wide_strb  = strb_mask << src_off;
    wide_wdata = {{DATA_LEN{1'b0}}, src_wdata} << {src_off, 3'b000};
    iss_wdata  = src_beat ? wide_wdata[2*DATA_LEN-1:DATA_LEN] : wide_wdata[DATA_LEN-1:0];
    iss_wstrb  = src_beat ? wide_strb[B2-1:B] : wide_strb[B-1:0];
  end

  // Load assembly: beat 1 supplies the upper half of a split access.
  logic [2*DATA_LEN-1:0] wide_rdata;
  logic [DATA_LEN-1:0]   load_raw, load_res;

  always_comb begin
    wide_rdata = beat_q ? {rdata, rbuf_q} : {{DATA_LEN{1'b0}}, rdata};
    load_raw   = DATA_LEN'(wide_rdata >> {off_q, 3'b000});
    load_res   = extend_load(load_raw, ld_type_q, lg_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      wdata_q        <= '0;
      ld_type_q      <= '0;
      lg_q           <= '0;
      is_load_q      <= 1'b0;
      cross_q        <= 1'b0;
      beat_q         <= 1'b0;
      rbuf_q         <= '0;
      out_valid      <= 1'b0;
      out_wdata      <= '0;
      out_wreg       <= '0;
      out_wd         <= 1'b0;
      out_fault      <= 1'b0;
      out_fault_addr <= '0;
      araddr         <= '0;
      arsize         <= '0;
      arvalid        <= 1'b0;
      rready         <= 1'b0;
      awaddr         <= '0;
      awsize         <= '0;
      awvalid        <= 1'b0;
      wdata          <= '0;
      wstrb          <= '0;
      wvalid         <= 1'b0;
      bready         <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (in_valid) begin
          addr_q         <= in_addr;
          wdata_q        <= in_wdata;
          ld_type_q      <= in_lt_n;
          lg_q           <= in_lg;
          is_load_q      <= in_is_load;
          cross_q        <= in_cross;
          beat_q         <= 1'b0;
          out_wreg       <= in_wreg;
          out_wd         <= in_wd;
          out_fault      <= 1'b0;
          out_fault_addr <= '0;
          if (!in_is_load && !in_is_store) begin
            out_wdata <= DATA_LEN'(in_addr);
            out_valid <= 1'b1;
            state_q   <= DONE;
          end else if (in_cross && !SPLIT_EN) begin
            out_wdata      <= '0;
            out_fault      <= 1'b1;
            out_fault_addr <= in_addr;
            out_valid      <= 1'b1;
            state_q        <= DONE;
          end else begin
            state_q <= ADDR;
            if (in_is_load) begin
              araddr  <= iss_addr;
              arsize  <= iss_size;
              arvalid <= 1'b1;
            end else begin
              awaddr  <= iss_addr;
              awsize  <= iss_size;
              awvalid <= 1'b1;
              wdata   <= iss_wdata;
              wstrb   <= iss_wstrb;
              wvalid  <= 1'b1;
            end
          end
        end

        ADDR: if (is_load_q) begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_q <= RESP;
          end
        end else begin
          // AW and W complete independently; leave once both are done.
          if (awvalid && awready) awvalid <= 1'b0;
          if (wvalid && wready)   wvalid  <= 1'b0;
          if ((!awvalid || awready) && (!wvalid || wready)) begin
            bready  <= 1'b1;
            state_q <= RESP;
          end
        end

        RESP: if (is_load_q) begin
          if (rvalid) begin
            rready <= 1'b0;
            if (rresp != 2'b00) begin
              out_wdata      <= '0;
              out_fault      <= 1'b1;
              out_fault_addr <= addr_q;
              out_valid      <= 1'b1;
              state_q        <= DONE;
            end else if (cross_q && !beat_q) begin
              rbuf_q  <= rdata;
              beat_q  <= 1'b1;
              araddr  <= iss_addr;
              arsize  <= iss_size;
              arvalid <= 1'b1;
              state_q <= ADDR;
            end else begin
              out_wdata <= load_res;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end
          end
        end else begin
          if (bvalid) begin
            bready <= 1'b0;
            if (bresp != 2'b00) begin
              out_wdata      <= '0;
              out_fault      <= 1'b1;
              out_fault_addr <= addr_q;
              out_valid      <= 1'b1;
              state_q        <= DONE;
            end else if (cross_q && !beat_q) begin
              beat_q  <= 1'b1;
              awaddr  <= iss_addr;
              awsize  <= iss_size;
              awvalid <= 1'b1;
              wdata   <= iss_wdata;
              wstrb   <= iss_wstrb;
              wvalid  <= 1'b1;
              state_q <= ADDR;
            end else begin
              out_wdata <= '0;
              out_valid <= 1'b1;
              state_q   <= DONE;
            end
          end
        end

        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state_q   <= IDLE;
        end
      endcase
    end
  end

endmodule
